rpn_calculator: RTL and testbench
=================================

RPN_CALCULATOR -- requirements
Module: rpn_calculator

Interface
REQ-001 Parameter DEPTH, default 16: operand stack entries.
REQ-002 Parameter OP_W, default 32: input operand width.
REQ-003 Parameter RES_W, default 64: stack entry and result width.
REQ-004 CLK  input  1: single clock; all state changes on its rising edge.
REQ-005 RST  input  1: reset, synchronous, active-high.
REQ-006 input_stb  input  1: input token valid.
REQ-007 input_data  input  OP_W: operand value, or operator code in bits [7:0].
REQ-008 is_input_operator  input  1: 1 = token is an operator, 0 = token is an operand.
REQ-009 input_ack  output  1: block can accept a token this cycle.
REQ-010 output_stb  output  1: result valid.
REQ-011 output_data  output  RES_W: expression result.
REQ-012 output_ack  input  1: downstream accepts the result.

Function
REQ-013 Input handshake: a token transfers on a rising edge where input_stb=1 and input_ack=1; no transfer occurs otherwise.
REQ-014 Output handshake: output_stb stays high and output_data stays stable until a rising edge with output_ack=1; output_stb clears on that edge.
REQ-015 FSM has three states: ACCEPT, EXEC and OUTPUT.
REQ-016 input_ack=1 only in ACCEPT and only when RST=0.
REQ-017 ACCEPT: an operand token is zero-extended to RES_W and pushed in the same edge, and the FSM stays in ACCEPT, giving a throughput of 1 operand per cycle.
REQ-018 ACCEPT: an operator token in {'+'(0x2B), '-'(0x2D), '*'(0x2A), '/'(0x2F)} is latched and the FSM moves to EXEC.
REQ-019 EXEC lasts exactly 1 cycle: pop B (top) and A (next), push f(A,B), stack depth decreases by 1, then return to ACCEPT.
REQ-020 Arithmetic is unsigned modulo 2^RES_W: A+B, A-B (wraps), the low RES_W bits of A*B, and floor(A/B).
REQ-021 Operator '='(0x3D): the FSM moves to OUTPUT and loads output_data with the top of stack, or with ERR_VALUE if the error flag is set or the stack depth is not 1.
REQ-022 OUTPUT: output_stb=1; on output_ack the stack empties, the error flag clears and the FSM returns to ACCEPT.
REQ-023 ERR_VALUE is all ones (0xFFFF_FFFF_FFFF_FFFF for RES_W=64).
REQ-024 The sticky error flag sets on any of the following:
- division by B=0;
- an operator with depth<2 (underflow);
- an operand push with depth=DEPTH (overflow);
- an unknown operator code.
REQ-025 On a flagged event the stack is left unchanged, except that an arithmetic error still consumes both operands and pushes ERR_VALUE.
REQ-026 Bits [OP_W-1:8] of an operator token are ignored.

Reset
REQ-027 While RST=1 at a rising edge:
- state = ACCEPT, stack depth = 0, error flag = 0;
- output_stb = 0, output_data = 0;
- input_ack = 0.
REQ-028 A reset asserted mid-expression or during OUTPUT discards all state, and no result is emitted.
REQ-029 input_ack rises in the first cycle after RST deasserts.

Structure
REQ-030 The shared package rpn_calculator_pkg holds:
- operator code constants;
- the FSM state enum;
- ERR_VALUE.
REQ-031 One sub-module, rpn_stack (parameters WIDTH and DEPTH), implements the LIFO.
REQ-032 rpn_stack has a push port, a pop-by-count port (0/1/2), top and next-top read ports, a depth output, and empty/full flags.
REQ-033 Push and pop may occur in the same cycle (EXEC: pop 2, push 1).
REQ-034 The stack depth counter has a width of clog2(DEPTH+1) bits.

Verification
REQ-035 Tokens 3, 4, '+', '=' with output_ack held high -> output_stb pulses once with output_data=7; input_ack=0 exactly during the EXEC and OUTPUT cycles.
REQ-036 Tokens 12, 2, '-', 18, '*', '=' -> output_data=180; tokens 2, 3, '-', '=' -> output_data=0xFFFF_FFFF_FFFF_FFFF (wrap).
REQ-037 Tokens 0xFFFF_FFFF, 0xFFFF_FFFF, '*', '=' -> output_data=0xFFFF_FFFE_0000_0001; tokens 11, 3, '/', '=' -> output_data=3.
REQ-038 Tokens 5, 0, '/', '=' -> ERR_VALUE; tokens 5, '+', '=' -> ERR_VALUE; a following expression 1, 1, '+', '=' -> output_data=2 (flag cleared).
REQ-039 Back-pressure: output_ack held low for 5 cycles -> output_stb and output_data stay stable and input_ack stays 0; transfer occurs on the first ack.
REQ-040 DEPTH=4, push 5 operands then '=' -> ERR_VALUE.
REQ-041 RST pulsed after tokens 3, 4 -> no output, and a subsequent 1, '=' -> output_data=1.

Source files
------------

// File: rtl/rpn_calculator_pkg.sv
// Shared definitions for the RPN calculator: operator codes, FSM states and
// the error sentinel value.
package rpn_calculator_pkg;

    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;
    localparam logic [7:0] OP_DIV = 8'h2F;
    localparam logic [7:0] OP_EQ  = 8'h3D;

    // Sentinel reported for any flagged expression; all ones for RES_W up to 64.
    localparam logic [63:0] ERR_VALUE = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ACCEPT,
        EXEC,
        OUTPUT
    } state_t;

endpackage

// File: rtl/rpn_calculator_stack.sv
// LIFO operand stack for the RPN calculator: one push and a pop of up to two
// entries per cycle, with top and next-top visible combinationally.
module rpn_stack #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic [1:0]                 pop_cnt,
    output logic [WIDTH-1:0]           top,
    output logic [WIDTH-1:0]           next_top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    base;
    logic [CW-1:0]    top_idx;
    logic [CW-1:0]    next_idx;

    // Pops are applied before the push, so EXEC writes its result where A lived.
    always_comb begin
        base     = cnt - CW'(pop_cnt);
        top_idx  = cnt - CW'(1);
        next_idx = cnt - CW'(2);
    end

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            cnt <= '0;
        end else begin
            cnt <= base + CW'(push);
        end
    end

    // NOTE: storage is not reset; only the depth counter defines which entries are live.
    always_ff @(posedge CLK) begin
        if (push && !RST && !clear) begin
            mem[base[AW-1:0]] <= push_data;
        end
    end

    assign top      = (cnt != '0)     ? mem[top_idx[AW-1:0]]  : '0;
    assign next_top = (cnt > CW'(1))  ? mem[next_idx[AW-1:0]] : '0;
    assign depth    = cnt;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));

endmodule

// File: rtl/rpn_calculator.sv
// Streaming RPN expression evaluator: operands push onto a stack, arithmetic
// operators combine the top two entries, '=' emits the single remaining value.
module rpn_calculator
    import rpn_calculator_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int OP_W  = 32,
    parameter int RES_W = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             input_stb,
    input  logic [OP_W-1:0]  input_data,
    input  logic             is_input_operator,
    output logic             input_ack,
    output logic             output_stb,
    output logic [RES_W-1:0] output_data,
    input  logic             output_ack
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [RES_W-1:0] ERR = RES_W'(ERR_VALUE);

    state_t           state, next_state;
    logic [7:0]       op_q;
    logic             err_q;
    logic [RES_W-1:0] out_q;

    logic             push, clear, err_set, load_op, load_out;
    logic [1:0]       pop_cnt;
    logic [RES_W-1:0] push_data, alu_res, top, next_top;
    logic [CW-1:0]    depth;
    logic             empty, full;

    rpn_stack #(.WIDTH(RES_W), .DEPTH(DEPTH)) u_stack (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (clear),
        .push      (push),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .top       (top),
        .next_top  (next_top),
        .depth     (depth),
        .empty     (empty),
        .full      (full)
    );

    // A is next-top, B is top; a zero divisor yields the error sentinel.
    always_comb begin
        alu_res = ERR;
        unique case (op_q)
            OP_ADD:  alu_res = next_top + top;
            OP_SUB:  alu_res = next_top - top;
            OP_MUL:  alu_res = next_top * top;
            OP_DIV:  alu_res = (top == '0) ? ERR : next_top / top;
            default: alu_res = ERR;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        push       = 1'b0;
        push_data  = '0;
        pop_cnt    = 2'd0;
        clear      = 1'b0;
        err_set    = 1'b0;
        load_op    = 1'b0;
        load_out   = 1'b0;
        unique case (state)
            ACCEPT: begin
                if (input_stb && !RST) begin
                    if (!is_input_operator) begin
                        if (full) begin
                            err_set = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_data = RES_W'(input_data);
                        end
                    end else begin
                        unique case (input_data[7:0])
                            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                                load_op    = 1'b1;
                                next_state = EXEC;
                            end
                            OP_EQ: begin
                                load_out   = 1'b1;
                                next_state = OUTPUT;
                            end
                            default: err_set = 1'b1;
                        endcase
                    end
                end
            end
            EXEC: begin
                next_state = ACCEPT;
                if (depth < CW'(2)) begin
                    err_set = 1'b1;
                end else begin
                    pop_cnt   = 2'd2;
                    push      = 1'b1;
                    push_data = alu_res;
                    err_set   = (op_q == OP_DIV) && (top == '0);
                end
            end
            OUTPUT: begin
                if (output_ack) begin
                    clear      = 1'b1;
                    next_state = ACCEPT;
                end
            end
            default: next_state = ACCEPT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ACCEPT;
            op_q  <= '0;
            err_q <= 1'b0;
            out_q <= '0;
        end else begin
            state <= next_state;
            if (load_op) begin
                op_q <= input_data[7:0];
            end
            if (clear) begin
                err_q <= 1'b0;
            end else if (err_set) begin
                err_q <= 1'b1;
            end
            if (load_out) begin
                out_q <= (err_q || depth != CW'(1)) ? ERR : top;
            end
        end
    end

    assign input_ack   = (state == ACCEPT) && !RST;
    assign output_stb  = (state == OUTPUT);
    assign output_data = out_q;

endmodule

// File: tb/tb_rpn_calculator.sv
// Directed self-checking bench for rpn_calculator; a DEPTH=4 instance runs in
// lockstep on the same inputs to exercise stack overflow.
module tb_rpn_calculator;

    localparam logic [63:0] ERRV = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        input_stb = 1'b0;
    logic [31:0] input_data = '0;
    logic        is_input_operator = 1'b0;
    logic        output_ack = 1'b1;

    logic        input_ack, output_stb;
    logic [63:0] output_data;
    logic        input_ack4, output_stb4;
    logic [63:0] output_data4;

    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int n0;

    rpn_calculator dut (
        .CLK(CLK), .RST(RST), .input_stb(input_stb), .input_data(input_data),
        .is_input_operator(is_input_operator), .input_ack(input_ack),
        .output_stb(output_stb), .output_data(output_data), .output_ack(output_ack)
    );

    rpn_calculator #(.DEPTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .input_stb(input_stb), .input_data(input_data),
        .is_input_operator(is_input_operator), .input_ack(input_ack4),
        .output_stb(output_stb4), .output_data(output_data4), .output_ack(output_ack)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (output_stb && output_ack && !RST) xfers++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] tok, input logic op);
        @(negedge CLK);
        input_stb = 1'b1;
        input_data = tok;
        is_input_operator = op;
        for (int i = 0; i < 20 && !input_ack; i++) @(negedge CLK);
        check("ack_wait", input_ack, 1'b1);
        @(posedge CLK);
        #1;
        input_stb = 1'b0;
        is_input_operator = 1'b0;
        input_data = '0;
    endtask

    task automatic get_result(input string tag, input logic [63:0] exp, input logic [63:0] exp4);
        int n;
        @(negedge CLK);
        for (int i = 0; i < 20 && !output_stb; i++) @(negedge CLK);
        check({tag, "_stb"}, output_stb, 1'b1);
        check(tag, output_data, exp);
        check({tag, "_d4"}, output_data4, exp4);
        n = xfers;
        output_ack = 1'b1;
        @(posedge CLK);
        #1;
        check({tag, "_stb_clr"}, output_stb, 1'b0);
        check({tag, "_xfer"}, 64'(xfers), 64'(n + 1));
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ack", input_ack, 1'b0);
        check("rst_stb", output_stb, 1'b0);
        check("rst_data", output_data, 64'd0);
        RST = 1'b0;
        #1;
        check("ack_after_rst", input_ack, 1'b1);

        // 3 4 + = with ack held high; input_ack low only in EXEC and OUTPUT
        n0 = xfers;
        send(32'd3, 1'b0);
        send(32'd4, 1'b0);
        send(32'h2B, 1'b1);
        @(negedge CLK);
        check("exec_ack", input_ack, 1'b0);
        @(negedge CLK);
        check("accept_ack", input_ack, 1'b1);
        send(32'h3D, 1'b1);
        @(negedge CLK);
        check("out_stb", output_stb, 1'b1);
        check("out_ack", input_ack, 1'b0);
        check("sum", output_data, 64'd7);
        @(negedge CLK);
        check("stb_pulse", output_stb, 1'b0);
        check("ack_back", input_ack, 1'b1);
        check("one_pulse", 64'(xfers), 64'(n0 + 1));

        send(32'd12, 1'b0); send(32'd2, 1'b0); send(32'h2D, 1'b1);
        send(32'd18, 1'b0); send(32'h2A, 1'b1); send(32'h3D, 1'b1);
        get_result("mul_chain", 64'd180, 64'd180);

        send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'h2D, 1'b1); send(32'h3D, 1'b1);
        get_result("sub_wrap", ERRV, ERRV);

        send(32'hFFFF_FFFF, 1'b0); send(32'hFFFF_FFFF, 1'b0); send(32'h2A, 1'b1); send(32'h3D, 1'b1);
        get_result("mul_wide", 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFE_0000_0001);

        send(32'd11, 1'b0); send(32'd3, 1'b0); send(32'h2F, 1'b1); send(32'h3D, 1'b1);
        get_result("div", 64'd3, 64'd3);

        send(32'd5, 1'b0); send(32'd0, 1'b0); send(32'h2F, 1'b1); send(32'h3D, 1'b1);
        get_result("div_zero", ERRV, ERRV);

        send(32'd5, 1'b0); send(32'h2B, 1'b1); send(32'h3D, 1'b1);
        get_result("underflow", ERRV, ERRV);

        send(32'd1, 1'b0); send(32'd1, 1'b0); send(32'h2B, 1'b1); send(32'h3D, 1'b1);
        get_result("err_cleared", 64'd2, 64'd2);

        send(32'd1, 1'b0); send(32'h78, 1'b1); send(32'h3D, 1'b1);
        get_result("bad_op", ERRV, ERRV);

        // upper operator bits are ignored
        send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'hABCD_002B, 1'b1); send(32'h3D, 1'b1);
        get_result("op_hi_bits", 64'd5, 64'd5);

        // exactly DEPTH=4 entries is legal on the small instance
        send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'd4, 1'b0);
        send(32'h2B, 1'b1); send(32'h2B, 1'b1); send(32'h2B, 1'b1); send(32'h3D, 1'b1);
        get_result("full_ok", 64'd10, 64'd10);

        // five operands overflow DEPTH=4; depth 5 on the large one also errors
        for (int i = 1; i <= 5; i++) send(32'(i), 1'b0);
        send(32'h3D, 1'b1);
        get_result("overflow", ERRV, ERRV);

        // back-pressure on the result
        output_ack = 1'b0;
        send(32'd3, 1'b0); send(32'd4, 1'b0); send(32'h2B, 1'b1); send(32'h3D, 1'b1);
        n0 = xfers;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_stb", output_stb, 1'b1);
            check("bp_data", output_data, 64'd7);
            check("bp_ack", input_ack, 1'b0);
        end
        output_ack = 1'b1;
        @(posedge CLK);
        #1;
        check("bp_stb_clr", output_stb, 1'b0);
        check("bp_xfer", 64'(xfers), 64'(n0 + 1));

        // reset mid-expression discards the operands
        n0 = xfers;
        send(32'd3, 1'b0); send(32'd4, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_mid_ack", input_ack, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rst_mid_ack_rise", input_ack, 1'b1);
        send(32'd1, 1'b0); send(32'h3D, 1'b1);
        get_result("after_rst", 64'd1, 64'd1);
        check("rst_mid_no_out", 64'(xfers), 64'(n0 + 1));

        // reset during OUTPUT drops the pending result
        output_ack = 1'b0;
        n0 = xfers;
        send(32'd9, 1'b0); send(32'h3D, 1'b1);
        @(negedge CLK);
        check("pre_rst_stb", output_stb, 1'b1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_out_stb", output_stb, 1'b0);
        check("rst_out_data", output_data, 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        output_ack = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_out_no_xfer", 64'(xfers), 64'(n0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
